my_sram_fifo: RTL and testbench

- Synchronous single-clock FIFO built on a small register-file SRAM (word_depth x BITS) with circular read/write pointers.
- Buffers a data stream between a producer (write) and a consumer (read).
- Flags data availability (ready) and dropped writes (overflow).
- Used as a generic rate-matching buffer inside one clock domain.

---
 rtl/my_sram_fifo.sv | 94 +++++++++
 tb/tb_my_sram_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/my_sram_fifo.sv
// my_sram_fifo: single-clock FIFO on a small register-file SRAM.
//
// It holds word_depth words of BITS bits each. Circular read and write
// pointers wrap naturally because word_depth = 2**addr_width.
//
// Ports:
//   clk      in   clock; all state updates on the rising edge
//   rst      in   asynchronous active-high reset
//   read     in   pop request
//   write    in   push request
//   data_in  in   word to push
//   data_out out  registered word popped by the last accepted read
//   ready    out  FIFO holds at least one word
//   overflow out  a write was dropped because the FIFO was full
//
// Build option: when MY_SRAM_FIFO_STICKY_OVF_EN is defined, overflow
// latches on the first dropped write and stays set until rst. Otherwise
// overflow is a one-cycle pulse for each dropped write.
module my_sram_fifo #(
  parameter int BITS       = 12,
  parameter int word_depth = 8,
  parameter int addr_width = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            read,
  input  logic            write,
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] data_out,
  output logic            ready,
  output logic            overflow
);

  localparam logic [addr_width:0] FULL = (addr_width+1)'(word_depth);

  logic [BITS-1:0]       mem [word_depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   count;
  logic [addr_width:0]   count_next;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  drop;

  // A read frees a slot in the same cycle, so a full FIFO still accepts
  // a write when it is paired with an accepted read. There is no bypass:
  // a read from an empty FIFO is ignored even when a write arrives with it.
  always_comb begin
    rd_ok = read && (count != '0);
    wr_ok = write && ((count < FULL) || rd_ok);
    drop  = write && !wr_ok;
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is left uninitialised by reset; only the control state clears.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      count <= count_next;
      // ready is registered from count_next so it moves on the same edge as count.
      ready <= (count_next != '0);
`ifdef MY_SRAM_FIFO_STICKY_OVF_EN
      overflow <= overflow | drop;
`else
      overflow <= drop;
`endif
    end
  end

endmodule

// File: tb/tb_my_sram_fifo.sv
// tb_my_sram_fifo: directed self-checking bench for my_sram_fifo.
// It drives inputs 1 ns after each rising edge and samples outputs there.
module tb_my_sram_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out;
  logic        ready;
  logic        overflow;

  int checks = 0;
  int errors = 0;

`ifdef MY_SRAM_FIFO_STICKY_OVF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  my_sram_fifo #(.BITS(12), .word_depth(8), .addr_width(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then return 1 ns after the edge with inputs idle.
  task automatic step(input logic r, input logic w, input logic [11:0] d);
    read = r;
    write = w;
    data_in = d;
    @(posedge clk);
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  // Pulse reset asynchronously, away from the clock edge.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #1 rst = 1'b1;
    #2;
    chk("por_data_out", 32'(data_out), 32'h0);
    chk("por_ready", 32'(ready), 32'h0);
    chk("por_overflow", 32'(overflow), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Mid-run asynchronous reset with count=5
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 12'(32'h0C0 + i));
    step(1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 12'h0C5);
    chk("mid_data_out_pre", 32'(data_out), 32'h0C0);
    chk("mid_ready_pre", 32'(ready), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 12'h0A0);
    chk("post_rst_ready", 32'(ready), 32'h1);
    step(1'b1, 1'b0, 12'h000);
    chk("post_rst_data", 32'(data_out), 32'h0A0);
    chk("post_rst_ready_empty", 32'(ready), 32'h0);

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 12'(32'h0E0 + i));
      chk("fill_ready", 32'(ready), 32'h1);
      chk("fill_overflow", 32'(overflow), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 12'h000);
      chk("drain_data", 32'(data_out), 32'h0E0 + 32'(i));
      chk("drain_ready", 32'(ready), (i < 7) ? 32'h1 : 32'h0);
    end

    // Overflow on a write to a full FIFO
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'(32'h0E0 + i));
    chk("full_no_ovf", 32'(overflow), 32'h0);
    step(1'b0, 1'b1, 12'h0E8);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_data_hold", 32'(data_out), 32'h0E7);
    step(1'b0, 1'b0, 12'h000);
    chk("ovf_after", 32'(overflow), 32'(STICKY));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 12'h000);
      chk("ovf_drain_data", 32'(data_out), 32'h0E0 + 32'(i));
    end
    chk("ovf_drain_ready", 32'(ready), 32'h0);
    chk("ovf_drain_flag", 32'(overflow), 32'(STICKY));
    step(1'b1, 1'b0, 12'h000);
    chk("ovf_no_e8", 32'(data_out), 32'h0E7);
    pulse_rst();
    chk("ovf_cleared_by_rst", 32'(overflow), 32'h0);
    @(posedge clk);
    #1;

    // Simultaneous read and write on a full FIFO
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'(32'h0B0 + i));
    step(1'b1, 1'b1, 12'h0F0);
    chk("simul_data", 32'(data_out), 32'h0B0);
    chk("simul_overflow", 32'(overflow), 32'h0);
    chk("simul_ready", 32'(ready), 32'h1);
    // Count must still be 8: a lone write is dropped.
    step(1'b0, 1'b1, 12'h0FF);
    chk("simul_still_full", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 12'h000);
      chk("simul_drain", 32'(data_out), (i < 7) ? (32'h0B1 + 32'(i)) : 32'h0F0);
    end
    chk("simul_empty", 32'(ready), 32'h0);

    // Reads from an empty FIFO
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 12'h000);
      chk("empty_rd_data", 32'(data_out), 32'h0F0);
      chk("empty_rd_ready", 32'(ready), 32'h0);
    end
    step(1'b1, 1'b1, 12'h0F4);
    chk("empty_rw_ready", 32'(ready), 32'h1);
    chk("empty_rw_data", 32'(data_out), 32'h0F0);
    step(1'b1, 1'b0, 12'h000);
    chk("empty_rw_read", 32'(data_out), 32'h0F4);
    chk("empty_rw_ready2", 32'(ready), 32'h0);
    pulse_rst();
    @(posedge clk);
    #1;

    // Streaming across the pointer wrap
    for (int k = 0; k < 26; k++) begin
      step(k >= 5, k < 21, 12'(32'h0E0 + k));
      if (k >= 5) chk("wrap_data", 32'(data_out), 32'h0E0 + 32'(k - 5));
    end
    chk("wrap_ready", 32'(ready), 32'h0);
    chk("wrap_overflow", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
